// File: rtl/ctrl_fsm_param.sv
// Parametrised multi-cycle control unit: fetch/decode/operand-load/execute/write-back/PC-advance
// sequencing with fetch and write handshakes, HALT/resume and a retired-instruction counter.
module ctrl_fsm_param #(
  parameter int unsigned OPW   = 3,
  parameter int unsigned OPERW = 2,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned SELW  = 3,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic             fetch_ready,
  input  logic             wr_ack,
  input  logic             resume,
  output logic             en_pc,
  output logic             en_ir,
  output logic [NSRC-1:0]  en_src,
  output logic             en_imm,
  output logic             en_io,
  output logic             en_ope,
  output logic             wr_req,
  output logic [SELW-1:0]  sel,
  output logic [OPERW-1:0] oper,
  output logic             halted,
  output logic [CNTW-1:0]  retired
);

  localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_SRC    = 4'd3,
    S_EXEC   = 4'd4,
    S_IMM    = 4'd5,
    S_IO     = 4'd6,
    S_WB     = 4'd7,
    S_NEXT   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t             r_state;
  logic [OPW-1:0]     r_op_q;
  logic [IDXW-1:0]    r_idx;
  logic [CNTW-1:0]    r_retired;
  logic               r_fetch;
  logic               r_en_pc;
  logic [NSRC-1:0]    r_en_src;
  logic               r_en_imm;
  logic               r_en_io;
  logic               r_en_ope;
  logic               r_wr_req;
  logic [SELW-1:0]    r_sel;
  logic [OPERW-1:0]   r_oper;
  logic               r_halted;

  state_t             w_nxt_state;
  logic [OPW-1:0]     w_nxt_op;
  logic [IDXW-1:0]    w_nxt_idx;
  logic               w_fetch;
  logic               w_en_pc;
  logic [NSRC-1:0]    w_en_src;
  logic               w_en_imm;
  logic               w_en_io;
  logic               w_en_ope;
  logic               w_wr_req;
  logic [SELW-1:0]    w_sel;
  logic [OPERW-1:0]   w_oper;
  logic               w_halted;

  // Next state, latched opcode and operand index
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op_q;
    w_nxt_idx   = r_idx;
    case (r_state)
      S_IDLE:  w_nxt_state = S_FETCH;
      S_FETCH: if (fetch_ready) w_nxt_state = S_DECODE;
      S_DECODE: begin
        w_nxt_op  = opcode;
        w_nxt_idx = '0;
        if (!opcode[OPW-1]) begin
          w_nxt_state = S_SRC;
        end else begin
          case (opcode[1:0])
            2'b00:   w_nxt_state = S_IMM;
            2'b01:   w_nxt_state = S_IO;
            2'b10:   w_nxt_state = S_NEXT;
            default: w_nxt_state = S_HALT;
          endcase
        end
      end
      S_SRC: begin
        if (r_idx == IDXW'(NSRC - 1)) w_nxt_state = S_EXEC;
        else                          w_nxt_idx   = r_idx + IDXW'(1);
      end
      S_EXEC, S_IMM, S_IO: w_nxt_state = S_WB;
      S_WB:    if (wr_ack) w_nxt_state = S_NEXT;
      S_NEXT:  w_nxt_state = S_FETCH;
      S_HALT:  if (resume) w_nxt_state = S_NEXT;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Moore decode of the state being entered, so outputs register with the state
  always_comb begin
    w_fetch  = 1'b0;
    w_en_pc  = 1'b0;
    w_en_src = '0;
    w_en_imm = 1'b0;
    w_en_io  = 1'b0;
    w_en_ope = 1'b0;
    w_wr_req = 1'b0;
    w_sel    = '0;
    w_oper   = '0;
    w_halted = 1'b0;
    case (w_nxt_state)
      S_FETCH: w_fetch = 1'b1;
      S_SRC: begin
        w_en_src = NSRC'(1) << w_nxt_idx;
        w_sel    = SELW'(w_nxt_idx) + SELW'(1);
      end
      S_EXEC: begin
        w_en_ope = 1'b1;
        w_oper   = w_nxt_op[OPERW-1:0];
      end
      S_IMM: w_en_imm = 1'b1;
      S_IO:  w_en_io  = 1'b1;
      S_WB: begin
        w_wr_req = 1'b1;
        if (!w_nxt_op[OPW-1])  w_sel = SELW'(NSRC + 1);
        else if (w_nxt_op[0])  w_sel = SELW'(NSRC + 3);
        else                   w_sel = SELW'(NSRC + 2);
      end
      S_NEXT: w_en_pc  = 1'b1;
      S_HALT: w_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op_q    <= '0;
      r_idx     <= '0;
      r_retired <= '0;
      r_fetch   <= 1'b0;
      r_en_pc   <= 1'b0;
      r_en_src  <= '0;
      r_en_imm  <= 1'b0;
      r_en_io   <= 1'b0;
      r_en_ope  <= 1'b0;
      r_wr_req  <= 1'b0;
      r_sel     <= '0;
      r_oper    <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_op_q   <= w_nxt_op;
      r_idx    <= w_nxt_idx;
      r_fetch  <= w_fetch;
      r_en_pc  <= w_en_pc;
      r_en_src <= w_en_src;
      r_en_imm <= w_en_imm;
      r_en_io  <= w_en_io;
      r_en_ope <= w_en_ope;
      r_wr_req <= w_wr_req;
      r_sel    <= w_sel;
      r_oper   <= w_oper;
      r_halted <= w_halted;
      if (r_state == S_NEXT) r_retired <= r_retired + CNTW'(1);
    end
  end

  // IR load follows instruction-memory valid directly while fetching
  assign en_ir   = r_fetch & fetch_ready;
  assign en_pc   = r_en_pc;
  assign en_src  = r_en_src;
  assign en_imm  = r_en_imm;
  assign en_io   = r_en_io;
  assign en_ope  = r_en_ope;
  assign wr_req  = r_wr_req;
  assign sel     = r_sel;
  assign oper    = r_oper;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Directed bench for ctrl_fsm_param: per-cycle expected output vectors go through a scoreboard queue.
module tb_ctrl_fsm_param;
  localparam int unsigned OPW = 3, OPERW = 2, NSRC = 2, SELW = 3, CNTW = 16, CNTWB = 4;
  localparam logic [2:0] D = 3'b110;
  typedef logic [33:0] vec_t;

  logic clk, rst_n, fetch_ready, wr_ack, resume;
  logic [OPW-1:0] opcode;
  logic en_pc, en_ir, en_imm, en_io, en_ope, wr_req, halted;
  logic [NSRC-1:0] en_src;
  logic [SELW-1:0] sel;
  logic [OPERW-1:0] oper;
  logic [CNTW-1:0] retired;
  logic b_en_pc, b_en_ir, b_en_imm, b_en_io, b_en_ope, b_wr_req, b_halted;
  logic [NSRC-1:0] b_en_src;
  logic [SELW-1:0] b_sel;
  logic [OPERW-1:0] b_oper;
  logic [CNTWB-1:0] b_retired;

  ctrl_fsm_param #(.OPW(OPW), .OPERW(OPERW), .NSRC(NSRC), .SELW(SELW), .CNTW(CNTW)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .fetch_ready(fetch_ready), .wr_ack(wr_ack),
    .resume(resume), .en_pc(en_pc), .en_ir(en_ir), .en_src(en_src), .en_imm(en_imm),
    .en_io(en_io), .en_ope(en_ope), .wr_req(wr_req), .sel(sel), .oper(oper),
    .halted(halted), .retired(retired));

  ctrl_fsm_param #(.OPW(OPW), .OPERW(OPERW), .NSRC(NSRC), .SELW(SELW), .CNTW(CNTWB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .fetch_ready(fetch_ready), .wr_ack(wr_ack),
    .resume(resume), .en_pc(b_en_pc), .en_ir(b_en_ir), .en_src(b_en_src), .en_imm(b_en_imm),
    .en_io(b_en_io), .en_ope(b_en_ope), .wr_req(b_wr_req), .sel(b_sel), .oper(b_oper),
    .halted(b_halted), .retired(b_retired));

  vec_t w_obs;
  assign w_obs = {en_pc, en_ir, en_src, en_imm, en_io, en_ope, wr_req, sel, oper, halted,
                  retired, b_retired};

  vec_t        sb_q[$];
  string       tag_q[$];
  int          n_chk, n_pass, n_fail;
  logic [15:0] exp_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic pc, input logic ir, input logic [1:0] src,
                              input logic imm, input logic io, input logic ope, input logic wr,
                              input logic [2:0] s, input logic [1:0] op, input logic h);
    logic [15:0] r;
    r = exp_ret;
    return {pc, ir, src, imm, io, ope, wr, s, op, h, r, r[3:0]};
  endfunction

  function automatic vec_t e0();                     return mk(0, 0, 2'b00, 0, 0, 0, 0, 3'd0, 2'd0, 0); endfunction
  function automatic vec_t ef(input logic fr);       return mk(0, fr, 2'b00, 0, 0, 0, 0, 3'd0, 2'd0, 0); endfunction
  function automatic vec_t es(input int k);          return mk(0, 0, 2'(1 << k), 0, 0, 0, 0, 3'(k + 1), 2'd0, 0); endfunction
  function automatic vec_t ee(input logic [1:0] o);  return mk(0, 0, 2'b00, 0, 0, 1, 0, 3'd0, o, 0); endfunction
  function automatic vec_t eimm();                   return mk(0, 0, 2'b00, 1, 0, 0, 0, 3'd0, 2'd0, 0); endfunction
  function automatic vec_t eio();                    return mk(0, 0, 2'b00, 0, 1, 0, 0, 3'd0, 2'd0, 0); endfunction
  function automatic vec_t ewb(input logic [2:0] s); return mk(0, 0, 2'b00, 0, 0, 0, 1, s, 2'd0, 0); endfunction
  function automatic vec_t en();                     return mk(1, 0, 2'b00, 0, 0, 0, 0, 3'd0, 2'd0, 0); endfunction
  function automatic vec_t eh();                     return mk(0, 0, 2'b00, 0, 0, 0, 0, 3'd0, 2'd0, 1); endfunction

  // Drive one cycle of inputs, queue its expected outputs, compare at the falling edge
  task automatic cyc(input string tag, input vec_t ev, input logic fr, input logic ack,
                     input logic res, input logic rn, input logic [2:0] op);
    vec_t  e;
    string t;
    rst_n = rn; fetch_ready = fr; wr_ack = ack; resume = res; opcode = op;
    sb_q.push_back(ev);
    tag_q.push_back(tag);
    @(negedge clk);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    n_chk++;
    assert (w_obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", t, w_obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; exp_ret = '0;
    rst_n = 1'b0; fetch_ready = 1'b1; wr_ack = 1'b0; resume = 1'b0; opcode = '0;
    @(posedge clk);
    #1;
    // T1: reset held with fetch_ready high, then release
    cyc("T1_rst0", e0(), 1, 0, 0, 0, D);
    cyc("T1_rel",  e0(), 1, 0, 0, 1, D);
    // T2: ALU op 001, noisy ack/resume outside their states
    cyc("T2_fetch", ef(1), 1, 1, 0, 1, D);
    cyc("T2_dec",   e0(),  1, 1, 0, 1, 3'b001);
    cyc("T2_src0",  es(0), 1, 1, 1, 1, D);
    cyc("T2_src1",  es(1), 1, 1, 1, 1, D);
    cyc("T2_exec",  ee(2'd1), 1, 1, 1, 1, D);
    cyc("T2_wb",    ewb(3'd3), 1, 1, 0, 1, D);
    cyc("T2_next",  en(), 1, 1, 0, 1, D);
    exp_ret++;
    // T3: LDI with wr_ack delayed three cycles
    cyc("T3_fetch", ef(1), 1, 1, 0, 1, D);
    cyc("T3_dec",   e0(),  1, 1, 0, 1, 3'b100);
    cyc("T3_imm",   eimm(), 1, 1, 0, 1, D);
    for (int i = 0; i < 3; i++) cyc("T3_wb_wait", ewb(3'd4), 1, 0, 0, 1, D);
    cyc("T3_wb_ack", ewb(3'd4), 1, 1, 0, 1, D);
    cyc("T3_next",   en(), 1, 1, 0, 1, D);
    exp_ret++;
    // T4: fetch stall then IN
    for (int i = 0; i < 5; i++) cyc("T4_stall", ef(0), 0, 1, 0, 1, D);
    cyc("T4_ready", ef(1), 1, 1, 0, 1, D);
    cyc("T4_dec",   e0(),  1, 1, 0, 1, 3'b101);
    cyc("T4_io",    eio(), 1, 1, 0, 1, D);
    cyc("T4_wb",    ewb(3'd5), 1, 1, 0, 1, D);
    cyc("T4_next",  en(), 1, 1, 0, 1, D);
    exp_ret++;
    // T5: HALT held ten cycles, then resume
    cyc("T5_fetch", ef(1), 1, 1, 0, 1, D);
    cyc("T5_dec",   e0(),  1, 1, 0, 1, 3'b111);
    for (int i = 0; i < 10; i++) cyc("T5_halt", eh(), 1, 1, 0, 1, D);
    cyc("T5_resume", eh(), 1, 1, 1, 1, D);
    cyc("T5_next",   en(), 1, 0, 0, 1, D);
    exp_ret++;
    // T5b: resume during WB must not release it
    cyc("T5b_fetch", ef(1), 1, 0, 1, 1, D);
    cyc("T5b_dec",   e0(),  1, 0, 1, 1, 3'b010);
    cyc("T5b_src0",  es(0), 1, 0, 0, 1, D);
    cyc("T5b_src1",  es(1), 1, 0, 0, 1, D);
    cyc("T5b_exec",  ee(2'd2), 1, 0, 0, 1, D);
    for (int i = 0; i < 2; i++) cyc("T5b_wb_res", ewb(3'd3), 1, 0, 1, 1, D);
    cyc("T5b_wb_ack", ewb(3'd3), 1, 1, 1, 1, D);
    cyc("T5b_next",   en(), 1, 1, 0, 1, D);
    exp_ret++;
    cyc("T5c_fetch", ef(1), 1, 1, 0, 1, D);
    cyc("T5c_dec",   e0(),  1, 1, 0, 1, 3'b110);
    cyc("T5c_next",  en(), 1, 1, 0, 1, D);
    exp_ret++;
    // T6: reset during WB with ack asserted aborts the instruction
    cyc("T6_fetch", ef(1), 1, 1, 0, 1, D);
    cyc("T6_dec",   e0(),  1, 1, 0, 1, 3'b100);
    cyc("T6_imm",   eimm(), 1, 1, 0, 1, D);
    cyc("T6_wb_rst", ewb(3'd4), 1, 1, 0, 0, D);
    exp_ret = '0;
    cyc("T6_idle", e0(), 1, 1, 0, 1, D);
    // T6b: sixteen NOPs wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      cyc("T6_nop_fetch", ef(1), 1, 1, 0, 1, D);
      cyc("T6_nop_dec",   e0(),  1, 1, 0, 1, 3'b110);
      cyc("T6_nop_next",  en(), 1, 1, 0, 1, D);
      exp_ret++;
    end
    cyc("T6_after_wrap", ef(1), 1, 1, 0, 1, D);
    n_chk++;
    assert (b_retired === 4'd0 && retired === 16'd16) n_pass++;
    else begin
      n_fail++;
      $error("FAIL T6_wrap: observed=%0d/%0d expected=0/16", b_retired, retired);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
